demux_s4: RTL and testbench

//  Registered 1:4 stream demultiplexer; inverse of the MUXS 4:1 selector. Routes an
//  N-bit word from one input stream to one of four output channels (A..D) chosen by
//  S1/S2, using the same select encoding as MUXS. Each channel holds one word behind a

---
 rtl/demux_s4_pkg.sv | 21 ++
 rtl/demux_s4_if.sv | 39 +++
 rtl/demux_s4_slot.sv | 74 +++++++
 rtl/demux_s4.sv | 67 ++++++
 tb/tb_demux_s4.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/demux_s4_pkg.sv
// demux_s4_pkg: shared types and constants for the 1:4 stream demultiplexer.
//   sel_t        - channel select, indexed by {S2,S1}
//   slot_state_t - per-channel EMPTY/FULL holding state
//   NCH          - number of output channels
package demux_s4_pkg;

    localparam int unsigned NCH = 4;

    typedef enum logic [1:0] {
        SEL_A = 2'b00,
        SEL_B = 2'b01,
        SEL_C = 2'b10,
        SEL_D = 2'b11
    } sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_s4_if.sv
// demux_s4_if: input stream, select lines and the four output channels of demux_s4.
//   IN/IN_VALID/IN_READY        - input word handshake
//   S1/S2                       - channel select ({S2,S1})
//   OUTx/OUTx_VALID/OUTx_READY  - channel x data and handshake (x = A..D)
//   CNTx                        - words accepted on channel x, modulo 2^CW
//   modport slave  : demultiplexer side
//   modport master : producer/consumer side
interface demux_s4_if #(
    parameter int unsigned N  = 90,
    parameter int unsigned CW = 16
);
    logic [N-1:0]  IN;
    logic          IN_VALID;
    logic          IN_READY;
    logic          S1;
    logic          S2;
    logic [N-1:0]  OUTA, OUTB, OUTC, OUTD;
    logic          OUTA_VALID, OUTB_VALID, OUTC_VALID, OUTD_VALID;
    logic          OUTA_READY, OUTB_READY, OUTC_READY, OUTD_READY;
    logic [CW-1:0] CNTA, CNTB, CNTC, CNTD;

    modport slave (
        input  IN, IN_VALID, S1, S2,
        input  OUTA_READY, OUTB_READY, OUTC_READY, OUTD_READY,
        output IN_READY,
        output OUTA, OUTB, OUTC, OUTD,
        output OUTA_VALID, OUTB_VALID, OUTC_VALID, OUTD_VALID,
        output CNTA, CNTB, CNTC, CNTD
    );

    modport master (
        output IN, IN_VALID, S1, S2,
        output OUTA_READY, OUTB_READY, OUTC_READY, OUTD_READY,
        input  IN_READY,
        input  OUTA, OUTB, OUTC, OUTD,
        input  OUTA_VALID, OUTB_VALID, OUTC_VALID, OUTD_VALID,
        input  CNTA, CNTB, CNTC, CNTD
    );
endinterface

// File: rtl/demux_s4_slot.sv
// demux_slot: one output channel - a single-word holding register with an
// EMPTY/FULL state and a wrapping accepted-word counter.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   load_i        - write data_i this edge (only raised when can_load_o=1)
//   data_i        - word to load
//   ready_i       - downstream consumes the held word
//   data_o        - held word (kept after drain)
//   valid_o       - register holds a word
//   cnt_o         - number of loads, modulo 2^CW
//   can_load_o    - slot is empty or is draining this cycle
module demux_slot
    import demux_s4_pkg::*;
#(
    parameter int unsigned N  = 90,
    parameter int unsigned CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [N-1:0]  data_i,
    input  logic          ready_i,
    output logic [N-1:0]  data_o,
    output logic          valid_o,
    output logic [CW-1:0] cnt_o,
    output logic          can_load_o
);

    slot_state_t   state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // A load takes priority over a drain so a simultaneous drain+load keeps the slot FULL.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SLOT_EMPTY: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                    data_d  = data_i;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            SLOT_FULL: begin
                if (load_i) begin
                    data_d = data_i;
                    cnt_d  = cnt_q + CW'(1);
                end else if (ready_i) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign data_o     = data_q;
    assign valid_o    = (state_q == SLOT_FULL);
    assign cnt_o      = cnt_q;
    assign can_load_o = (state_q == SLOT_EMPTY) | ready_i;

endmodule

// File: rtl/demux_s4.sv
// demux_s4: registered 1:4 stream demultiplexer. A word on IN is routed to channel
// A..D selected by {S2,S1} at the accept edge; each channel holds one word behind
// a valid/ready handshake and counts accepted words.
//   CLK   - clock, rising edge
//   RST_N - asynchronous reset, active low
//   bus   - demux_s4_if.slave: input stream, select, four output channels
module demux_s4
    import demux_s4_pkg::*;
#(
    parameter int unsigned N  = 90,
    parameter int unsigned CW = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    demux_s4_if.slave   bus
);

    sel_t           sel;
    logic [NCH-1:0] load;
    logic [NCH-1:0] ready;
    logic [NCH-1:0] valid;
    logic [NCH-1:0] can_load;
    logic [N-1:0]   data [NCH];
    logic [CW-1:0]  cnt  [NCH];

    assign sel   = sel_t'({bus.S2, bus.S1});
    assign ready = {bus.OUTD_READY, bus.OUTC_READY, bus.OUTB_READY, bus.OUTA_READY};

    assign bus.IN_READY = can_load[sel];

    // Only the selected slot may see a load strobe; the others are never written.
    always_comb begin
        load      = '0;
        load[sel] = bus.IN_VALID & can_load[sel];
    end

    for (genvar g = 0; g < NCH; g++) begin : g_slot
        demux_slot #(
            .N  (N),
            .CW (CW)
        ) u_slot (
            .clk_i      (CLK),
            .rst_ni     (RST_N),
            .load_i     (load[g]),
            .data_i     (bus.IN),
            .ready_i    (ready[g]),
            .data_o     (data[g]),
            .valid_o    (valid[g]),
            .cnt_o      (cnt[g]),
            .can_load_o (can_load[g])
        );
    end

    assign bus.OUTA       = data[0];
    assign bus.OUTB       = data[1];
    assign bus.OUTC       = data[2];
    assign bus.OUTD       = data[3];
    assign bus.OUTA_VALID = valid[0];
    assign bus.OUTB_VALID = valid[1];
    assign bus.OUTC_VALID = valid[2];
    assign bus.OUTD_VALID = valid[3];
    assign bus.CNTA       = cnt[0];
    assign bus.CNTB       = cnt[1];
    assign bus.CNTC       = cnt[2];
    assign bus.CNTD       = cnt[3];

endmodule

// File: tb/tb_demux_s4.sv
module tb_demux_s4;

    localparam int unsigned N  = 90;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   run_cmp = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    demux_s4_if #(.N(N), .CW(CW)) bus ();

    demux_s4 #(.N(N), .CW(CW)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    // DUT outputs gathered into arrays by channel index
    logic [N-1:0]  o_d [4];
    logic          o_v [4];
    logic [CW-1:0] o_c [4];
    logic          rdy [4];
    always_comb begin
        o_d[0] = bus.OUTA; o_d[1] = bus.OUTB; o_d[2] = bus.OUTC; o_d[3] = bus.OUTD;
        o_v[0] = bus.OUTA_VALID; o_v[1] = bus.OUTB_VALID;
        o_v[2] = bus.OUTC_VALID; o_v[3] = bus.OUTD_VALID;
        o_c[0] = bus.CNTA; o_c[1] = bus.CNTB; o_c[2] = bus.CNTC; o_c[3] = bus.CNTD;
        rdy[0] = bus.OUTA_READY; rdy[1] = bus.OUTB_READY;
        rdy[2] = bus.OUTC_READY; rdy[3] = bus.OUTD_READY;
    end

    // Reference model: per-channel word, occupancy and count, advanced by the
    // handshake rules once per rising edge.
    logic [N-1:0]  m_d [4];
    logic          m_v [4];
    logic [CW-1:0] m_c [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_d[i] <= '0;
                m_v[i] <= 1'b0;
                m_c[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i == int'({bus.S2, bus.S1}) && bus.IN_VALID && (!m_v[i] || rdy[i])) begin
                    m_d[i] <= bus.IN;
                    m_v[i] <= 1'b1;
                    m_c[i] <= m_c[i] + 16'd1;
                end else if (m_v[i] && rdy[i]) begin
                    m_v[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // Every falling edge: all outputs against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("model_data[%0d]", i), 128'(o_d[i]), 128'(m_d[i]));
                chk($sformatf("model_valid[%0d]", i), 128'(o_v[i]), 128'(m_v[i]));
                chk($sformatf("model_cnt[%0d]", i), 128'(o_c[i]), 128'(m_c[i]));
            end
            chk("model_in_ready", 128'(bus.IN_READY),
                128'(!m_v[{bus.S2, bus.S1}] || rdy[{bus.S2, bus.S1}]));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ready(input logic [3:0] r);
        {bus.OUTD_READY, bus.OUTC_READY, bus.OUTB_READY, bus.OUTA_READY} = r;
    endtask

    task automatic do_reset();
        bus.IN_VALID = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Present one word and wait (bounded) for the edge that accepts it.
    task automatic send(input logic [N-1:0] d, input logic [1:0] s);
        bit done = 1'b0;
        bus.IN = d;
        {bus.S2, bus.S1} = s;
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            done = bus.IN_READY;
            tick();
        end
        bus.IN_VALID = 1'b0;
        chk("send_accepted", 128'(done), 128'(1));
    endtask

    initial begin
        bus.IN = '0;
        bus.IN_VALID = 1'b0;
        bus.S1 = 1'b0;
        bus.S2 = 1'b0;
        set_ready(4'b0000);
        @(posedge clk);
        run_cmp = 1'b1;

        // 1. reset with a word offered
        bus.IN = 90'd999;
        bus.IN_VALID = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 128'(bus.IN_READY), 128'(1));
        chk("rst_valid_a", 128'(bus.OUTA_VALID), 128'(0));
        chk("rst_outa", 128'(bus.OUTA), 128'(0));
        chk("rst_cnta", 128'(bus.CNTA), 128'(0));
        bus.IN_VALID = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid_a", 128'(bus.OUTA_VALID), 128'(0));

        // 2. routing, all consumers ready
        set_ready(4'b1111);
        send(90'd4532, 2'b00);
        chk("route_outa", 128'(bus.OUTA), 128'(4532));
        chk("route_va", 128'(bus.OUTA_VALID), 128'(1));
        send(90'd124, 2'b01);
        chk("route_outb", 128'(bus.OUTB), 128'(124));
        chk("route_va_drained", 128'(bus.OUTA_VALID), 128'(0));
        chk("route_outa_held", 128'(bus.OUTA), 128'(4532));
        send(90'd255, 2'b10);
        chk("route_outc", 128'(bus.OUTC), 128'(255));
        send(90'd2345, 2'b11);
        chk("route_outd", 128'(bus.OUTD), 128'(2345));
        chk("route_vd", 128'(bus.OUTD_VALID), 128'(1));
        tick();
        chk("route_vd_drained", 128'(bus.OUTD_VALID), 128'(0));
        chk("route_cntb", 128'(bus.CNTB), 128'(1));
        chk("route_cntd", 128'(bus.CNTD), 128'(1));

        // 3. backpressure on B
        do_reset();
        set_ready(4'b1101);
        send(90'd124, 2'b01);
        bus.IN = 90'd777;
        bus.IN_VALID = 1'b1;
        #1;
        chk("bp_in_ready_low", 128'(bus.IN_READY), 128'(0));
        tick();
        chk("bp_outb_held", 128'(bus.OUTB), 128'(124));
        chk("bp_cntb", 128'(bus.CNTB), 128'(1));
        set_ready(4'b1111);
        #1;
        chk("bp_in_ready_high", 128'(bus.IN_READY), 128'(1));
        tick();
        bus.IN_VALID = 1'b0;
        chk("bp_outb_new", 128'(bus.OUTB), 128'(777));
        chk("bp_vb", 128'(bus.OUTB_VALID), 128'(1));
        chk("bp_cntb2", 128'(bus.CNTB), 128'(2));
        tick();

        // 4. isolation: B stalled, send to C
        do_reset();
        set_ready(4'b0000);
        send(90'd124, 2'b01);
        bus.IN = 90'd255;
        {bus.S2, bus.S1} = 2'b10;
        #1;
        chk("iso_in_ready", 128'(bus.IN_READY), 128'(1));
        send(90'd255, 2'b10);
        chk("iso_outc", 128'(bus.OUTC), 128'(255));
        chk("iso_outb", 128'(bus.OUTB), 128'(124));
        chk("iso_vb", 128'(bus.OUTB_VALID), 128'(1));
        chk("iso_cntb", 128'(bus.CNTB), 128'(1));

        // 5. counter wrap on D
        do_reset();
        set_ready(4'b1111);
        {bus.S2, bus.S1} = 2'b11;
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus.IN = N'(i);
            tick();
        end
        chk("wrap_cntd_max", 128'(bus.CNTD), 128'(16'hFFFF));
        chk("wrap_outd_last", 128'(bus.OUTD), 128'(65534));
        bus.IN = 90'd65535;
        tick();
        bus.IN_VALID = 1'b0;
        chk("wrap_cntd_zero", 128'(bus.CNTD), 128'(0));
        chk("wrap_outd", 128'(bus.OUTD), 128'(65535));
        chk("wrap_cnta", 128'(bus.CNTA), 128'(0));
        tick();

        // 6. asynchronous reset mid-cycle with A and C full
        do_reset();
        set_ready(4'b0000);
        send(90'd4532, 2'b00);
        send(90'd255, 2'b10);
        chk("mid_va", 128'(bus.OUTA_VALID), 128'(1));
        chk("mid_vc", 128'(bus.OUTC_VALID), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_va_async", 128'(bus.OUTA_VALID), 128'(0));
        chk("mid_vc_async", 128'(bus.OUTC_VALID), 128'(0));
        chk("mid_outc", 128'(bus.OUTC), 128'(0));
        chk("mid_cntc", 128'(bus.CNTC), 128'(0));
        chk("mid_in_ready", 128'(bus.IN_READY), 128'(1));
        tick();
        rst_n = 1'b1;
        set_ready(4'b1111);
        send(90'd4532, 2'b00);
        chk("resume_outa", 128'(bus.OUTA), 128'(4532));
        chk("resume_cnta", 128'(bus.CNTA), 128'(1));
        tick();

        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
